// File: rtl/deemph_pkg.sv
// Shared types, default coefficients and rounding helper for the de-emphasis IIR.
package deemph_pkg;

  localparam int unsigned DEEMPH_DATA_WIDTH = 32;
  localparam int unsigned DEEMPH_PROD_WIDTH = 2 * DEEMPH_DATA_WIDTH;
  localparam int unsigned DEEMPH_QUANT_BITS = 10;

  localparam logic signed [31:0] DEEMPH_B0 = 32'sd178;
  localparam logic signed [31:0] DEEMPH_B1 = 32'sd178;
  localparam logic signed [31:0] DEEMPH_A1 = -32'sd666;

  typedef enum logic [1:0] {
    S_READ,
    S_CALC,
    S_WRITE
  } state_t;

  // Shift right by qbits rounding toward zero, like C integer division.
  function automatic logic signed [DEEMPH_PROD_WIDTH-1:0] dequantize(
    input logic signed [DEEMPH_PROD_WIDTH-1:0] p,
    input int unsigned                         qbits
  );
    logic signed [DEEMPH_PROD_WIDTH-1:0] bias;
    bias = p[DEEMPH_PROD_WIDTH-1] ?
           ((DEEMPH_PROD_WIDTH'(1) << qbits) - DEEMPH_PROD_WIDTH'(1)) : '0;
    return (p + bias) >>> qbits;
  endfunction

endpackage

// File: rtl/deemph_top.sv
// deemph_iir wrapped between an input and an output FWFT FIFO for file-driven benches.
module deemph_fifo #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  do_wr, do_rd;

  assign full  = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign empty = (count == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

module deemph_top
  import deemph_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEEMPH_DATA_WIDTH,
  parameter int unsigned FIFO_LOG2  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_wr_en,
  input  logic [DATA_WIDTH-1:0] in_din,
  output logic                  in_full,
  input  logic                  out_rd_en,
  output logic [DATA_WIDTH-1:0] out_dout,
  output logic                  out_empty
);

  logic [DATA_WIDTH-1:0] core_in_dout, core_out_din;
  logic                  core_in_empty, core_in_rd_en;
  logic                  core_out_full, core_out_wr_en;

  deemph_fifo #(.WIDTH(DATA_WIDTH), .DEPTH_LOG2(FIFO_LOG2)) u_in_fifo (
    .clock (clock),
    .reset (reset),
    .wr_en (in_wr_en),
    .din   (in_din),
    .full  (in_full),
    .rd_en (core_in_rd_en),
    .dout  (core_in_dout),
    .empty (core_in_empty)
  );

  deemph_iir #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .clock     (clock),
    .reset     (reset),
    .in_dout   (core_in_dout),
    .in_empty  (core_in_empty),
    .in_rd_en  (core_in_rd_en),
    .out_din   (core_out_din),
    .out_full  (core_out_full),
    .out_wr_en (core_out_wr_en)
  );

  deemph_fifo #(.WIDTH(DATA_WIDTH), .DEPTH_LOG2(FIFO_LOG2)) u_out_fifo (
    .clock (clock),
    .reset (reset),
    .wr_en (core_out_wr_en),
    .din   (core_out_din),
    .full  (core_out_full),
    .rd_en (out_rd_en),
    .dout  (out_dout),
    .empty (out_empty)
  );

endmodule

// File: rtl/deemph_iir.sv
// First-order IIR de-emphasis core between two FWFT FIFOs.
// Optional DEEMPH_SATURATE_EN clamps the output instead of wrapping.
module deemph_iir
  import deemph_pkg::*;
#(
  parameter int unsigned       DATA_WIDTH = DEEMPH_DATA_WIDTH,
  parameter int unsigned       QUANT_BITS = DEEMPH_QUANT_BITS,
  parameter logic signed [31:0] B0        = DEEMPH_B0,
  parameter logic signed [31:0] B1        = DEEMPH_B1,
  parameter logic signed [31:0] A1        = DEEMPH_A1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_dout,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] out_din,
  input  logic                  out_full,
  output logic                  out_wr_en
);

  localparam int unsigned PW = DEEMPH_PROD_WIDTH;
  localparam int unsigned SW = PW + 2;

  localparam logic signed [PW-1:0] B0_EXT = PW'(B0);
  localparam logic signed [PW-1:0] B1_EXT = PW'(B1);
  localparam logic signed [PW-1:0] A1_EXT = PW'(A1);

  state_t state, state_nxt;

  logic signed [DATA_WIDTH-1:0] x_cur, x_prev, y_cur, y_prev;
  logic signed [PW-1:0]         p0, p1, p2;
  logic signed [PW-1:0]         d0, d1, d2;
  logic signed [SW-1:0]         sum;
  logic signed [DATA_WIDTH-1:0] y_new;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_READ;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    case (state)
      S_READ: begin
        if (!in_empty) begin
          in_rd_en  = 1'b1;
          state_nxt = S_CALC;
        end
      end
      S_CALC: state_nxt = S_WRITE;
      S_WRITE: begin
        if (!out_full) begin
          out_wr_en = 1'b1;
          state_nxt = S_READ;
        end
      end
      default: state_nxt = S_READ;
    endcase
  end

  always_comb begin
    p0 = B0_EXT * PW'(x_cur);
    p1 = B1_EXT * PW'(x_prev);
    p2 = A1_EXT * PW'(y_prev);
    d0 = dequantize(p0, QUANT_BITS);
    d1 = dequantize(p1, QUANT_BITS);
    d2 = dequantize(p2, QUANT_BITS);
    // Sum kept at full product width: its low DATA_WIDTH bits equal the
    // narrow wrapped sum, and clamping sees terms that overflow DATA_WIDTH.
    sum = SW'(d0) + SW'(d1) - SW'(d2);
  end

`ifdef DEEMPH_SATURATE_EN
  localparam logic signed [SW-1:0] Y_MAX = (SW'(1) << (DATA_WIDTH - 1)) - SW'(1);
  localparam logic signed [SW-1:0] Y_MIN = -Y_MAX - SW'(1);

  always_comb begin
    if (sum > Y_MAX)      y_new = Y_MAX[DATA_WIDTH-1:0];
    else if (sum < Y_MIN) y_new = Y_MIN[DATA_WIDTH-1:0];
    else                  y_new = sum[DATA_WIDTH-1:0];
  end
`else
  logic sum_unused;
  assign sum_unused = ^sum[SW-1:DATA_WIDTH];
  assign y_new      = sum[DATA_WIDTH-1:0];
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_cur   <= '0;
      x_prev  <= '0;
      y_cur   <= '0;
      y_prev  <= '0;
      out_din <= '0;
    end else begin
      case (state)
        S_READ: begin
          if (!in_empty) x_cur <= $signed(in_dout);
        end
        S_CALC: begin
          y_cur   <= y_new;
          out_din <= y_new;
          x_prev  <= x_cur;
        end
        S_WRITE: begin
          if (!out_full) y_prev <= y_cur;
        end
        default: ;
      endcase
    end
  end

endmodule
